// File: rtl/battle_pkg.sv
// Shared types and constants for the battle engine: FSM states, USB
// keycodes for the WASD/ENTER controls and the move-grid geometry.
package battle_pkg;

  typedef enum logic [3:0] {
    WAIT,
    LOAD,
    SELECT,
    ORDER,
    ATTACK1,
    ATTACK2,
    END_TURN,
    WIN,
    LOSE
  } state_t;

  localparam logic [7:0] KEY_W     = 8'h1A;
  localparam logic [7:0] KEY_A     = 8'h04;
  localparam logic [7:0] KEY_S     = 8'h16;
  localparam logic [7:0] KEY_D     = 8'h07;
  localparam logic [7:0] KEY_ENTER = 8'h28;

  // Moves are laid out on a grid with this many columns.
  localparam int GRID_COLS = 2;

endpackage

// File: rtl/battle_engine_key_press.sv
// Key edge detector: a press is a nonzero keycode that differs from the
// keycode seen on the previous cycle, so a held key yields one pulse.
module key_press (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [7:0] keycode,
  output logic       press,
  output logic [7:0] key
);

  logic [7:0] prev;

  // Remember last cycle's keycode for edge detection.
  always_ff @(posedge Clk) begin
    if (Reset) prev <= 8'd0;
    else       prev <= keycode;
  end

  assign press = (keycode != 8'd0) && (keycode != prev);
  assign key   = keycode;

endmodule

// File: rtl/battle_engine.sv
// Turn-based battle controller: loads both teams' HP from an external
// stats table, lets the player pick a move on a grid, orders attacks by
// speed, applies externally computed damage and tracks faints until one
// side is wiped out.
module battle_engine
  import battle_pkg::*;
#(
  parameter int TEAM_SIZE  = 3,
  parameter int MOVE_SLOTS = 4,
  parameter int HP_W       = 8
) (
  input  logic                          Clk,
  input  logic                          Reset,
  input  logic                          is_battle,
  input  logic [7:0]                    keycode,
  input  logic [TEAM_SIZE*3-1:0]        team,
  input  logic [TEAM_SIZE*3-1:0]        enemy_team,
  output logic [2:0]                    load_id,
  input  logic [HP_W-1:0]               load_hp,
  input  logic [7:0]                    player_speed,
  input  logic [7:0]                    enemy_speed,
  input  logic [HP_W-1:0]               player_dmg,
  input  logic [HP_W-1:0]               enemy_dmg,
  output logic [$clog2(MOVE_SLOTS)-1:0] move_index,
  output logic [$clog2(TEAM_SIZE)-1:0]  my_cur,
  output logic [$clog2(TEAM_SIZE)-1:0]  enemy_cur,
  output logic [2:0]                    enemy_cur_id,
  output logic [HP_W-1:0]               my_hp,
  output logic [HP_W-1:0]               enemy_hp,
  output logic                          result,
  output logic                          end_battle
);

  localparam int MI_W  = $clog2(MOVE_SLOTS);
  localparam int CUR_W = $clog2(TEAM_SIZE);
  localparam int LC_W  = $clog2(2 * TEAM_SIZE);

  localparam logic [LC_W-1:0]  LOAD_LAST = LC_W'(2 * TEAM_SIZE - 1);
  localparam logic [LC_W-1:0]  TS_LC     = LC_W'(TEAM_SIZE);
  localparam logic [CUR_W-1:0] CUR_LAST  = CUR_W'(TEAM_SIZE - 1);
  localparam logic [MI_W:0]    COLS_X    = (MI_W + 1)'(GRID_COLS);
  localparam logic [MI_W:0]    SLOTS_X   = (MI_W + 1)'(MOVE_SLOTS);

  state_t state;
  logic [LC_W-1:0]  cnt;
  logic             player_first;
  logic [HP_W-1:0]  p_hp  [TEAM_SIZE];
  logic [HP_W-1:0]  p_max [TEAM_SIZE];
  logic [HP_W-1:0]  e_hp  [TEAM_SIZE];
  logic [HP_W-1:0]  e_max [TEAM_SIZE];
  logic [2:0]       team_ids  [TEAM_SIZE];
  logic [2:0]       enemy_ids [TEAM_SIZE];

  logic             press;
  logic [7:0]       key;
  logic             enter;
  logic             load_enemy;
  logic [CUR_W-1:0] load_slot;
  logic [MI_W:0]    idx_x;
  logic [HP_W-1:0]  p_hit;
  logic [HP_W-1:0]  e_hit;

  // Saturating damage: never below zero, never above the slot's max HP.
  function automatic logic [HP_W-1:0] apply_dmg(input logic [HP_W-1:0] hp,
                                                 input logic [HP_W-1:0] dmg,
                                                 input logic [HP_W-1:0] cap);
    logic [HP_W-1:0] r;
    r = (dmg >= hp) ? '0 : hp - dmg;
    return (r > cap) ? cap : r;
  endfunction

  key_press u_key (
    .Clk     (Clk),
    .Reset   (Reset),
    .keycode (keycode),
    .press   (press),
    .key     (key)
  );

  for (genvar g = 0; g < TEAM_SIZE; g++) begin : g_ids
    assign team_ids[g]  = team[g*3 +: 3];
    assign enemy_ids[g] = enemy_team[g*3 +: 3];
  end

  assign enter      = press && (key == KEY_ENTER);
  assign load_enemy = (cnt >= TS_LC);
  assign load_slot  = load_enemy ? CUR_W'(cnt - TS_LC) : cnt[CUR_W-1:0];
  assign load_id    = load_enemy ? enemy_ids[load_slot] : team_ids[load_slot];
  assign idx_x      = {1'b0, move_index};

  assign my_hp        = p_hp[my_cur];
  assign enemy_hp     = e_hp[enemy_cur];
  assign enemy_cur_id = enemy_ids[enemy_cur];
  assign p_hit        = apply_dmg(p_hp[my_cur], enemy_dmg, p_max[my_cur]);
  assign e_hit        = apply_dmg(e_hp[enemy_cur], player_dmg, e_max[enemy_cur]);

  // Battle FSM with all state, HP tables and pulse outputs registered.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state        <= WAIT;
      cnt          <= '0;
      my_cur       <= '0;
      enemy_cur    <= '0;
      move_index   <= '0;
      player_first <= 1'b0;
      result       <= 1'b0;
      end_battle   <= 1'b0;
      for (int i = 0; i < TEAM_SIZE; i++) begin
        p_hp[i]  <= '0;
        p_max[i] <= '0;
        e_hp[i]  <= '0;
        e_max[i] <= '0;
      end
    end else begin
      end_battle <= 1'b0;
      result     <= 1'b0;
      unique case (state)
        WAIT: begin
          if (is_battle) begin
            state <= LOAD;
            cnt   <= '0;
          end
        end
        LOAD: begin
          if (load_enemy) begin
            e_hp[load_slot]  <= load_hp;
            e_max[load_slot] <= load_hp;
          end else begin
            p_hp[load_slot]  <= load_hp;
            p_max[load_slot] <= load_hp;
          end
          if (cnt == LOAD_LAST) begin
            cnt        <= '0;
            my_cur     <= '0;
            enemy_cur  <= '0;
            move_index <= '0;
            state      <= SELECT;
          end else begin
            cnt <= cnt + LC_W'(1);
          end
        end
        SELECT: begin
          if (press) begin
            case (key)
              KEY_W:     if (idx_x >= COLS_X) move_index <= move_index - MI_W'(GRID_COLS);
              KEY_S:     if (idx_x + COLS_X < SLOTS_X) move_index <= move_index + MI_W'(GRID_COLS);
              KEY_A:     if (move_index[0]) move_index <= move_index - MI_W'(1);
              KEY_D:     if (!move_index[0]) move_index <= move_index + MI_W'(1);
              KEY_ENTER: state <= ORDER;
              default:   ;
            endcase
          end
        end
        ORDER: begin
          // Ties go to the enemy.
          player_first <= (player_speed > enemy_speed);
          state        <= ATTACK1;
        end
        ATTACK1: begin
          if (enter) begin
            if (player_first) begin
              e_hp[enemy_cur] <= e_hit;
              state <= (e_hit == '0) ? END_TURN : ATTACK2;
            end else begin
              p_hp[my_cur] <= p_hit;
              state <= (p_hit == '0) ? END_TURN : ATTACK2;
            end
          end
        end
        ATTACK2: begin
          if (enter) begin
            if (player_first) p_hp[my_cur]    <= p_hit;
            else              e_hp[enemy_cur] <= e_hit;
            state <= END_TURN;
          end
        end
        END_TURN: begin
          move_index <= '0;
          if (p_hp[my_cur] == '0) begin
            if (my_cur == CUR_LAST) begin
              state      <= LOSE;
              end_battle <= 1'b1;
            end else begin
              my_cur <= my_cur + CUR_W'(1);
              state  <= SELECT;
            end
          end else if (e_hp[enemy_cur] == '0) begin
            if (enemy_cur == CUR_LAST) begin
              state      <= WIN;
              end_battle <= 1'b1;
              result     <= 1'b1;
            end else begin
              enemy_cur <= enemy_cur + CUR_W'(1);
              state     <= SELECT;
            end
          end else begin
            state <= SELECT;
          end
        end
        WIN:     state <= WAIT;
        LOSE:    state <= WAIT;
        default: state <= WAIT;
      endcase
    end
  end

endmodule

// File: tb/tb_battle_engine.sv
// Scoreboard bench for battle_engine: expected outputs are queued as each
// stimulus is driven and compared once the DUT has clocked it in.
module tb_battle_engine;
  import battle_pkg::*;

  logic       Clk, Reset, is_battle;
  logic [7:0] keycode;
  logic [8:0] team, enemy_team;
  logic [2:0] load_id;
  logic [7:0] load_hp, player_speed, enemy_speed, player_dmg, enemy_dmg;
  logic [1:0] move_index, my_cur, enemy_cur;
  logic [2:0] enemy_cur_id;
  logic [7:0] my_hp, enemy_hp;
  logic       result, end_battle;

  battle_engine #(.TEAM_SIZE(3), .MOVE_SLOTS(4), .HP_W(8)) dut (
    .Clk(Clk), .Reset(Reset), .is_battle(is_battle), .keycode(keycode),
    .team(team), .enemy_team(enemy_team), .load_id(load_id), .load_hp(load_hp),
    .player_speed(player_speed), .enemy_speed(enemy_speed),
    .player_dmg(player_dmg), .enemy_dmg(enemy_dmg), .move_index(move_index),
    .my_cur(my_cur), .enemy_cur(enemy_cur), .enemy_cur_id(enemy_cur_id),
    .my_hp(my_hp), .enemy_hp(enemy_hp), .result(result), .end_battle(end_battle)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // External stats table: max HP per mon ID.
  function automatic logic [7:0] stat_hp(input logic [2:0] id);
    case (id)
      3'd1:    return 8'd50;
      3'd2:    return 8'd60;
      3'd3:    return 8'd70;
      default: return 8'd40;
    endcase
  endfunction
  always_comb load_hp = stat_hp(load_id);

  localparam int O_MYHP = 0, O_ENHP = 1, O_IDX = 2, O_MYCUR = 3, O_ENCUR = 4,
                 O_ENID = 5, O_END = 6, O_RES = 7, O_LID = 8;

  typedef struct {
    string tag;
    int    sel;
    int    exp;
  } exp_t;
  exp_t sb[$];

  int checks = 0;
  int errors = 0;

  function automatic logic [31:0] obs(input int sel);
    case (sel)
      O_MYHP:  return {24'd0, my_hp};
      O_ENHP:  return {24'd0, enemy_hp};
      O_IDX:   return {30'd0, move_index};
      O_MYCUR: return {30'd0, my_cur};
      O_ENCUR: return {30'd0, enemy_cur};
      O_ENID:  return {29'd0, enemy_cur_id};
      O_END:   return {31'd0, end_battle};
      O_RES:   return {31'd0, result};
      default: return {29'd0, load_id};
    endcase
  endfunction

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic expect_out(input string tag, input int sel, input int exp);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check_val(e.tag, obs(e.sel), e.exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic key_edge(input logic [7:0] k);
    keycode = k;
    step(1);
    keycode = 8'd0;
  endtask

  task automatic tap(input logic [7:0] k);
    key_edge(k);
    step(1);
  endtask

  task automatic start_battle();
    is_battle = 1'b1;
    step(1);
    is_battle = 1'b0;
    step(6);
  endtask

  initial begin
    int n;
    Reset = 1'b1; is_battle = 1'b0; keycode = 8'd0;
    team = {3'd3, 3'd2, 3'd1};
    enemy_team = {3'd6, 3'd5, 3'd4};
    player_speed = 8'd9; enemy_speed = 8'd5;
    player_dmg = 8'd45; enemy_dmg = 8'd10;
    step(2);
    expect_out("rst_my_hp", O_MYHP, 0);
    expect_out("rst_en_hp", O_ENHP, 0);
    expect_out("rst_idx", O_IDX, 0);
    expect_out("rst_my_cur", O_MYCUR, 0);
    expect_out("rst_en_cur", O_ENCUR, 0);
    expect_out("rst_end", O_END, 0);
    expect_out("rst_res", O_RES, 0);
    drain();
    Reset = 1'b0;
    step(1);

    // Load: six cycles walking player then enemy IDs.
    is_battle = 1'b1;
    step(1);
    is_battle = 1'b0;
    for (int k = 0; k < 6; k++) begin
      expect_out($sformatf("load_id_%0d", k), O_LID, k + 1);
      drain();
      step(1);
    end
    expect_out("load_my_hp", O_MYHP, 50);
    expect_out("load_en_hp", O_ENHP, 40);
    expect_out("load_en_id", O_ENID, 4);
    drain();

    // Grid navigation.
    tap(KEY_D); tap(KEY_S);
    expect_out("grid_ds", O_IDX, 3); drain();
    keycode = KEY_W; step(5); keycode = 8'd0; step(1);
    expect_out("grid_w_held", O_IDX, 1); drain();
    tap(KEY_D);
    expect_out("grid_d_odd", O_IDX, 1); drain();
    tap(KEY_A); tap(KEY_A);
    expect_out("grid_a_at0", O_IDX, 0); drain();
    tap(KEY_W); tap(8'h05);
    expect_out("grid_w_at0", O_IDX, 0); drain();

    // Player faster, one-hit KO on enemy: ATTACK2 skipped.
    tap(KEY_ENTER);
    key_edge(KEY_ENTER);
    expect_out("ko_en_hp", O_ENHP, 0);
    expect_out("ko_my_hp", O_MYHP, 50);
    drain();
    step(1);
    expect_out("ko_en_cur", O_ENCUR, 1);
    expect_out("ko_en_id", O_ENID, 5);
    expect_out("ko_en_hp_next", O_ENHP, 40);
    expect_out("ko_my_hp_after", O_MYHP, 50);
    drain();
    tap(KEY_D);
    expect_out("ko_back_select", O_IDX, 1); drain();

    // Speed tie: enemy strikes first, then player.
    player_speed = 8'd5; enemy_speed = 8'd5; player_dmg = 8'd10; enemy_dmg = 8'd10;
    tap(KEY_ENTER);
    key_edge(KEY_ENTER);
    expect_out("tie_my_hp", O_MYHP, 40);
    expect_out("tie_en_hp", O_ENHP, 40);
    drain();
    step(1);
    key_edge(KEY_ENTER);
    expect_out("tie2_en_hp", O_ENHP, 30);
    expect_out("tie2_my_hp", O_MYHP, 40);
    drain();
    step(1);
    expect_out("tie_idx_clr", O_IDX, 0);
    expect_out("tie_my_cur", O_MYCUR, 0);
    drain();

    // Finish off remaining enemies (saturating damage) to win.
    player_speed = 8'd9; enemy_speed = 8'd5; player_dmg = 8'd200;
    tap(KEY_ENTER);
    key_edge(KEY_ENTER);
    expect_out("sat_en_hp", O_ENHP, 0); drain();
    step(1);
    expect_out("win_en_cur2", O_ENCUR, 2);
    expect_out("win_en_id2", O_ENID, 6);
    drain();
    tap(KEY_ENTER);
    key_edge(KEY_ENTER);
    step(1);
    expect_out("win_end", O_END, 1);
    expect_out("win_res", O_RES, 1);
    drain();
    step(1);
    expect_out("win_end_clr", O_END, 0);
    expect_out("win_res_clr", O_RES, 0);
    drain();
    tap(KEY_D);
    expect_out("wait_ignores_d", O_IDX, 0); drain();

    // New battle: enemy faster and overwhelming, player loses.
    start_battle();
    expect_out("b2_my_hp", O_MYHP, 50);
    expect_out("b2_en_hp", O_ENHP, 40);
    expect_out("b2_en_cur", O_ENCUR, 0);
    drain();
    player_speed = 8'd5; enemy_speed = 8'd9; player_dmg = 8'd1; enemy_dmg = 8'd255;
    for (int i = 0; i < 3; i++) begin
      tap(KEY_ENTER);
      key_edge(KEY_ENTER);
      expect_out($sformatf("lose_hp0_%0d", i), O_MYHP, 0); drain();
      if (i < 2) begin
        step(1);
        expect_out($sformatf("lose_cur_%0d", i), O_MYCUR, i + 1);
        expect_out($sformatf("lose_next_hp_%0d", i), O_MYHP, 60 + 10 * i);
        drain();
      end
    end
    n = 0;
    while (end_battle !== 1'b1 && n < 10) begin
      step(1);
      n++;
    end
    check_val("lose_end", {31'd0, end_battle}, 32'd1);
    check_val("lose_res", {31'd0, result}, 32'd0);
    step(1);
    expect_out("lose_end_clr", O_END, 0); drain();

    // Reset during ATTACK1.
    player_speed = 8'd9; enemy_speed = 8'd5; player_dmg = 8'd10; enemy_dmg = 8'd10;
    start_battle();
    tap(KEY_D);
    tap(KEY_ENTER);
    Reset = 1'b1;
    step(1);
    Reset = 1'b0;
    expect_out("ra_my_hp", O_MYHP, 0);
    expect_out("ra_en_hp", O_ENHP, 0);
    expect_out("ra_my_cur", O_MYCUR, 0);
    expect_out("ra_en_cur", O_ENCUR, 0);
    expect_out("ra_idx", O_IDX, 0);
    expect_out("ra_end", O_END, 0);
    drain();
    tap(KEY_D);
    expect_out("ra_wait", O_IDX, 0); drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/battle_engine.md
BATTLE_ENGINE -- requirements
Module: battle_engine

Interface
REQ-001 Parameters SHALL be: TEAM_SIZE, default 3, mons per side (2..4); MOVE_SLOTS, default 4, even move count on a 2-column grid; HP_W, default 8, HP width.
REQ-002 Ports, in this order: Clk in 1 clock; Reset in 1 synchronous active-high reset; is_battle in 1 start request; keycode in 8 USB keycode; team in TEAM_SIZE*3 player mon IDs; enemy_team in TEAM_SIZE*3 CPU mon IDs; load_id out 3 mon ID under HP fetch; load_hp in HP_W max HP of load_id; player_speed in 8; enemy_speed in 8; player_dmg in HP_W damage player deals to enemy; enemy_dmg in HP_W damage enemy deals to player; move_index out clog2(MOVE_SLOTS) cursor; my_cur out clog2(TEAM_SIZE) active player slot; enemy_cur out clog2(TEAM_SIZE) active CPU slot; enemy_cur_id out 3; my_hp out HP_W; enemy_hp out HP_W; result out 1 (1=win); end_battle out 1 pulse.

Function
REQ-003 States SHALL be: WAIT, LOAD, SELECT, ORDER, ATTACK1, ATTACK2, END_TURN, WIN, LOSE.
REQ-004 A key press SHALL be registered only when keycode is nonzero and differs from the previous cycle's keycode; a held key SHALL count once.
REQ-005 In WAIT, is_battle=1 SHALL move the block to LOAD next cycle; otherwise the block SHALL stay in WAIT.
REQ-006 LOAD SHALL last exactly 2*TEAM_SIZE cycles, one HP slot per cycle.
- Cycle k < TEAM_SIZE: load_id=team[k]; player HP[k] and player max[k] latch load_hp.
- Remaining cycles: the same for enemy_team.
- On exit: my_cur, enemy_cur and move_index clear to 0; next state SELECT.
REQ-007 SELECT cursor moves:
- W: -2 if index>=2.
- S: +2 if index+2<MOVE_SLOTS.
- A: -1 if index odd.
- D: +1 if index even.
- Any move off the grid: no change.
- ENTER: go to ORDER.
REQ-008 ORDER SHALL last one cycle and latch player_first = (player_speed > enemy_speed); a tie SHALL make the enemy act first.
REQ-009 In ATTACK1, on ENTER, the first attacker's damage SHALL be subtracted from the defender's active HP, saturating at 0.
- Defender HP reaches 0: go to END_TURN.
- Otherwise: go to ATTACK2.
REQ-010 In ATTACK2, on ENTER, the second attacker's damage SHALL be applied with the same saturation; next state END_TURN.
REQ-011 Each attack SHALL be applied exactly once per state visit; damage inputs SHALL be sampled on the ENTER cycle.
REQ-012 END_TURN SHALL last one cycle.
- Player active HP=0: LOSE if my_cur=TEAM_SIZE-1, else my_cur+1.
- Enemy active HP=0: WIN if enemy_cur=TEAM_SIZE-1, else enemy_cur+1.
- move_index clears to 0; otherwise go to SELECT.
REQ-013 Only one mon faints per turn (REQ-009); the player check SHALL still take priority if both HPs are 0.
REQ-014 WIN SHALL drive end_battle=1 and result=1 for exactly one cycle; LOSE SHALL drive end_battle=1 and result=0 for one cycle; both SHALL then go to WAIT.
REQ-015 Outputs:
- my_hp and enemy_hp SHALL show the active slots' HP.
- enemy_cur_id SHALL equal enemy_team[enemy_cur].
- result SHALL be 0 outside WIN.
REQ-016 is_battle deasserting mid-battle SHALL be ignored.
REQ-017 Non-WASD/ENTER keys SHALL be ignored in every state.

Reset
REQ-018 Reset SHALL return the block to WAIT and clear to 0: all HP registers, my_cur, enemy_cur, move_index, the LOAD counter, the previous-keycode register, player_first, result and end_battle; this SHALL hold in any state, including mid-LOAD and mid-attack.

Structure
REQ-019 Package battle_pkg SHALL hold the state enum, the keycode constants (W=0x1A, A=0x04, S=0x16, D=0x07, ENTER=0x28) and the grid column constant 2.
REQ-020 Sub-module key_press SHALL implement REQ-004 and output a one-cycle press pulse plus the keycode.
REQ-021 The stats table and the damage calculator SHALL remain external.

Verification
REQ-022 Load with TEAM_SIZE=3 and load_hp=50,60,70 / 40,40,40: LOAD lasts 6 cycles; then my_hp=50, enemy_hp=40, state SELECT.
REQ-023 Grid moves from index 0 with MOVE_SLOTS=4:
- D then S: index 3.
- A at index 0: stays 0.
- W held 5 cycles at index 3: index 1 (one press).
REQ-024 Turn with player_speed=9, enemy_speed=5, player_dmg=45, enemy_dmg=10, enemy HP 40: enemy HP is 0 after the first ENTER; ATTACK2 is skipped; enemy_cur=1; my_hp unchanged.
REQ-025 Speed tie 5/5: enemy attacks first; my_hp=50-10=40 after the first ENTER.
REQ-026 Defeat all three CPU mons: one-cycle end_battle=1 with result=1; then WAIT. Defeat all player mons: end_battle=1, result=0.
REQ-027 Assert Reset during ATTACK1: next cycle state WAIT, all HP 0, my_cur=0, end_battle=0.
